// File: rtl/ex_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_md_unit
// Brief    : EX-stage multiply/divide unit owning HI/LO; single-cycle MULT,
//            32-cycle radix-2 restoring divide that stalls the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module ex_md_unit #(
  parameter logic [31:0] HILO_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_valid,
  input  logic [3:0]  md_op,
  input  logic        md_cancel,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic [31:0] EX_MD_data,
  output logic        md_stall,
  output logic        md_busy
);

  localparam logic [3:0] c_OP_MULT  = 4'd1;
  localparam logic [3:0] c_OP_MULTU = 4'd2;
  localparam logic [3:0] c_OP_DIV   = 4'd3;
  localparam logic [3:0] c_OP_DIVU  = 4'd4;
  localparam logic [3:0] c_OP_MFHI  = 4'd5;
  localparam logic [3:0] c_OP_MFLO  = 4'd6;
  localparam logic [3:0] c_OP_MTHI  = 4'd7;
  localparam logic [3:0] c_OP_MTLO  = 4'd8;
  localparam logic [4:0] c_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;

  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [4:0]  r_counter;
  logic [31:0] r_quot;      // dividend bits shift out the top, quotient bits in the bottom
  logic [31:0] r_rem;
  logic [31:0] r_divisor;
  logic [31:0] r_rs_raw;
  logic        r_q_neg;
  logic        r_r_neg;
  logic        r_div_zero;

  logic        w_issue;
  logic        w_is_div;
  logic        w_issue_div;
  logic        w_div_signed;
  logic [31:0] w_rs_abs;
  logic [31:0] w_rt_abs;

  logic        w_mul_signed;
  logic [63:0] w_mul_a;
  logic [63:0] w_mul_b;
  logic [63:0] w_product;

  logic [32:0] w_trial;
  logic [32:0] w_diff;
  logic        w_qbit;
  logic [31:0] w_rem_next;
  logic [31:0] w_quot_fix;
  logic [31:0] w_rem_fix;

  // --------------------------------------------------------------------------
  // Issue decode
  // --------------------------------------------------------------------------
  assign w_issue      = (r_state == S_IDLE) & md_valid & ~md_cancel;
  assign w_is_div     = (md_op == c_OP_DIV) | (md_op == c_OP_DIVU);
  assign w_issue_div  = w_issue & w_is_div;
  assign w_div_signed = (md_op == c_OP_DIV);

  assign w_rs_abs = (w_div_signed & rs_data[31]) ? (32'd0 - rs_data) : rs_data;
  assign w_rt_abs = (w_div_signed & rt_data[31]) ? (32'd0 - rt_data) : rt_data;

  // Low 64 bits of a product of 64-bit extended operands is exact for both signednesses
  assign w_mul_signed = (md_op == c_OP_MULT);
  assign w_mul_a      = {{32{w_mul_signed & rs_data[31]}}, rs_data};
  assign w_mul_b      = {{32{w_mul_signed & rt_data[31]}}, rt_data};
  assign w_product    = w_mul_a * w_mul_b;

  // --------------------------------------------------------------------------
  // Restoring divide step: a clear borrow bit means trial >= divisor
  // --------------------------------------------------------------------------
  assign w_trial    = {r_rem, r_quot[31]};
  assign w_diff     = w_trial - {1'b0, r_divisor};
  assign w_qbit     = ~w_diff[32];
  assign w_rem_next = w_qbit ? w_diff[31:0] : w_trial[31:0];

  assign w_quot_fix = r_q_neg ? (32'd0 - r_quot) : r_quot;
  assign w_rem_fix  = r_r_neg ? (32'd0 - r_rem)  : r_rem;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    md_stall     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue_div) begin
          w_state_next = S_RUN;
          md_stall     = 1'b1;
        end
      end
      S_RUN: begin
        if (md_cancel) begin
          w_state_next = S_IDLE;
        end else begin
          md_stall = 1'b1;
          if (r_counter == c_LAST_ITER) begin
            w_state_next = S_DONE;
          end
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign md_busy = (r_state != S_IDLE);

  // --------------------------------------------------------------------------
  // HI/LO and divider datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi       <= HILO_RESET;
      r_lo       <= HILO_RESET;
      r_counter  <= 5'd0;
      r_quot     <= 32'd0;
      r_rem      <= 32'd0;
      r_divisor  <= 32'd0;
      r_rs_raw   <= 32'd0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_issue) begin
            case (md_op)
              c_OP_MULT, c_OP_MULTU: begin
                r_hi <= w_product[63:32];
                r_lo <= w_product[31:0];
              end
              c_OP_MTHI: r_hi <= rs_data;
              c_OP_MTLO: r_lo <= rs_data;
              c_OP_DIV, c_OP_DIVU: begin
                r_quot     <= w_rs_abs;
                r_divisor  <= w_rt_abs;
                r_rem      <= 32'd0;
                r_rs_raw   <= rs_data;
                r_q_neg    <= w_div_signed & (rs_data[31] ^ rt_data[31]);
                r_r_neg    <= w_div_signed & rs_data[31];
                r_div_zero <= (rt_data == 32'd0);
                r_counter  <= 5'd0;
              end
              default: begin
              end
            endcase
          end
        end
        S_RUN: begin
          if (!md_cancel) begin
            r_rem     <= w_rem_next;
            r_quot    <= {r_quot[30:0], w_qbit};
            r_counter <= r_counter + 5'd1;
          end
        end
        S_DONE: begin
          if (!md_cancel) begin
            if (r_div_zero) begin
              r_lo <= 32'hFFFF_FFFF;
              r_hi <= r_rs_raw;
            end else begin
              r_lo <= w_quot_fix;
              r_hi <= w_rem_fix;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Move-from result, read straight from the architectural registers
  // --------------------------------------------------------------------------
  always_comb begin
    EX_MD_data = 32'd0;
    if (md_valid && (md_op == c_OP_MFHI)) begin
      EX_MD_data = r_hi;
    end else if (md_valid && (md_op == c_OP_MFLO)) begin
      EX_MD_data = r_lo;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ex_md_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_md_unit
// Brief    : Directed self-checking bench for ex_md_unit with an arithmetic
//            HI/LO model compared on every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_md_unit;

  localparam logic [3:0] c_MULT = 4'd1, c_MULTU = 4'd2, c_DIV = 4'd3, c_DIVU = 4'd4;
  localparam logic [3:0] c_MFHI = 4'd5, c_MFLO = 4'd6, c_MTHI = 4'd7, c_MTLO = 4'd8;
  localparam logic [31:0] c_HILO_RESET = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        md_valid;
  logic [3:0]  md_op;
  logic        md_cancel;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] EX_MD_data;
  logic        md_stall;
  logic        md_busy;

  int checks = 0;
  int errors = 0;

  ex_md_unit #(.HILO_RESET(c_HILO_RESET)) dut (
    .clk        (clk),
    .reset      (reset),
    .md_valid   (md_valid),
    .md_op      (md_op),
    .md_cancel  (md_cancel),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .EX_MD_data (EX_MD_data),
    .md_stall   (md_stall),
    .md_busy    (md_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference arithmetic: {HI, LO}
  function automatic logic [63:0] mul_model(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (is_signed) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  function automatic logic [63:0] div_model(input logic is_signed, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (!is_signed) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a);
    sb = $signed(b);
    return {32'(sa % sb), 32'(sa / sb)};
  endfunction

  // Model: m_age counts cycles since a divide was accepted (0 = no divide);
  // ages 1..32 are the stalled iterations, age 33 is the final non-stalled cycle.
  logic [31:0] m_hi, m_lo, m_pend_hi, m_pend_lo;
  int          m_age  = 0;
  logic        m_init = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_hi   <= c_HILO_RESET;
      m_lo   <= c_HILO_RESET;
      m_age  <= 0;
      m_init <= 1'b1;
    end else if (m_age != 0) begin
      if (md_cancel) begin
        m_age <= 0;
      end else if (m_age == 33) begin
        m_hi  <= m_pend_hi;
        m_lo  <= m_pend_lo;
        m_age <= 0;
      end else begin
        m_age <= m_age + 1;
      end
    end else if (md_valid && !md_cancel) begin
      case (md_op)
        c_MULT, c_MULTU: {m_hi, m_lo} <= mul_model(md_op == c_MULT, rs_data, rt_data);
        c_MTHI: m_hi <= rs_data;
        c_MTLO: m_lo <= rs_data;
        c_DIV, c_DIVU: begin
          {m_pend_hi, m_pend_lo} <= div_model(md_op == c_DIV, rs_data, rt_data);
          m_age <= 1;
        end
        default: begin
        end
      endcase
    end
  end

  always @(negedge clk) begin
    logic [31:0] exp_data;
    logic        exp_stall;
    if (m_init) begin
      exp_data = 32'd0;
      if (md_valid && md_op == c_MFHI) exp_data = m_hi;
      if (md_valid && md_op == c_MFLO) exp_data = m_lo;
      exp_stall = (m_age == 0 && md_valid && !md_cancel && (md_op == c_DIV || md_op == c_DIVU))
                || (m_age >= 1 && m_age <= 32 && !md_cancel);
      check("cyc_data", EX_MD_data, exp_data);
      check("cyc_stall", {31'd0, md_stall}, {31'd0, exp_stall});
      check("cyc_busy", {31'd0, md_busy}, {31'd0, m_age != 0});
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(posedge clk);
    #1;
    md_valid  = 1'b1;
    md_op     = op;
    rs_data   = rs;
    rt_data   = rt;
    md_cancel = 1'b0;
  endtask

  task automatic expect_mf(input string name, input logic [3:0] op, input logic [31:0] exp);
    drive(op, 32'h0, 32'h0);
    @(negedge clk);
    check(name, EX_MD_data, exp);
  endtask

  // Counts stalled cycles from the current cycle and stops in the release cycle
  task automatic finish_div(input string name);
    int n = 0;
    @(negedge clk);
    while (md_stall && n < 100) begin
      n++;
      @(negedge clk);
    end
    check(name, 32'(n), 32'd33);
    check({name, "_done_busy"}, {31'd0, md_busy}, 32'd1);
  endtask

  task automatic run_div(input string name, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    drive(op, rs, rt);
    finish_div(name);
  endtask

  initial begin
    reset = 1'b1; md_valid = 1'b0; md_op = 4'd0; md_cancel = 1'b0;
    rs_data = 32'd0; rt_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_stall", {31'd0, md_stall}, 32'd0);
    check("rst_busy", {31'd0, md_busy}, 32'd0);
    check("rst_data", EX_MD_data, 32'd0);
    expect_mf("rst_hi", c_MFHI, 32'h0);
    expect_mf("rst_lo", c_MFLO, 32'h0);

    // Multiplies
    drive(c_MULT, 32'hFFFF_FFFD, 32'd5);
    expect_mf("mult_hi", c_MFHI, 32'hFFFF_FFFF);
    expect_mf("mult_lo", c_MFLO, 32'hFFFF_FFF1);
    drive(c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    expect_mf("multu_hi", c_MFHI, 32'hFFFF_FFFE);
    expect_mf("multu_lo", c_MFLO, 32'h0000_0001);

    // Divides
    run_div("div_neg7_2", c_DIV, 32'hFFFF_FFF9, 32'd2);
    expect_mf("div_neg7_hi", c_MFHI, 32'hFFFF_FFFF);
    expect_mf("div_neg7_lo", c_MFLO, 32'hFFFF_FFFD);
    run_div("divu_zero", c_DIVU, 32'h1234_5678, 32'd0);
    expect_mf("divu_zero_lo", c_MFLO, 32'hFFFF_FFFF);
    expect_mf("divu_zero_hi", c_MFHI, 32'h1234_5678);
    run_div("divu_100_7", c_DIVU, 32'd100, 32'd7);
    expect_mf("divu_100_7_lo", c_MFLO, 32'd14);
    expect_mf("divu_100_7_hi", c_MFHI, 32'd2);
    run_div("div_zero_neg", c_DIV, 32'hFFFF_FFF8, 32'd0);
    expect_mf("div_zero_neg_hi", c_MFHI, 32'hFFFF_FFF8);
    run_div("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    expect_mf("div_ovf_lo", c_MFLO, 32'h8000_0000);
    expect_mf("div_ovf_hi", c_MFHI, 32'h0);
    run_div("div_7_neg2", c_DIV, 32'd7, 32'hFFFF_FFFE);
    expect_mf("div_7_neg2_lo", c_MFLO, 32'hFFFF_FFFD);
    expect_mf("div_7_neg2_hi", c_MFHI, 32'd1);

    // Cancel in issue cycle, in RUN with immediate re-issue, and in the final cycle
    drive(c_MTHI, 32'h1111_1111, 32'h0);
    drive(c_MTLO, 32'h1111_1111, 32'h0);
    drive(c_DIV, 32'd50, 32'd5);
    md_cancel = 1'b1;
    @(negedge clk);
    check("cancel_issue_stall", {31'd0, md_stall}, 32'd0);
    expect_mf("cancel_issue_hi", c_MFHI, 32'h1111_1111);
    drive(c_DIV, 32'd50, 32'd5);
    repeat (10) @(posedge clk);
    #1 md_cancel = 1'b1;
    @(negedge clk);
    check("cancel_run_stall", {31'd0, md_stall}, 32'd0);
    @(posedge clk);
    #1 md_cancel = 1'b0;
    finish_div("div_reissue");
    expect_mf("reissue_lo", c_MFLO, 32'd10);
    expect_mf("reissue_hi", c_MFHI, 32'd0);
    drive(c_MTLO, 32'h1111_1111, 32'h0);
    run_div("div_cancel_done", c_DIVU, 32'd40, 32'd3);
    md_cancel = 1'b1;
    expect_mf("cancel_done_lo", c_MFLO, 32'h1111_1111);

    // Reset in the middle of a divide
    drive(c_MTHI, 32'h5555_5555, 32'h0);
    drive(c_DIV, 32'd100, 32'd7);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; md_valid = 1'b0; md_op = 4'd0;
    @(negedge clk);
    check("midrst_busy", {31'd0, md_busy}, 32'd0);
    check("midrst_stall", {31'd0, md_stall}, 32'd0);
    expect_mf("midrst_hi", c_MFHI, 32'h0);
    run_div("div_9_3", c_DIV, 32'd9, 32'd3);
    expect_mf("div_9_3_lo", c_MFLO, 32'd3);
    expect_mf("div_9_3_hi", c_MFHI, 32'd0);

    // Moves, invalid reads, undefined opcode
    drive(c_MTHI, 32'hCAFE_BABE, 32'h0);
    drive(c_MTLO, 32'hDEAD_BEEF, 32'h0);
    expect_mf("mthi_rd", c_MFHI, 32'hCAFE_BABE);
    expect_mf("mtlo_rd", c_MFLO, 32'hDEAD_BEEF);
    drive(c_MFHI, 32'h0, 32'h0);
    md_valid = 1'b0;
    @(negedge clk);
    check("mf_invalid", EX_MD_data, 32'h0);
    drive(4'd12, 32'h0BAD_0BAD, 32'h3);
    @(negedge clk);
    check("op12_busy", {31'd0, md_busy}, 32'd0);
    expect_mf("op12_hi", c_MFHI, 32'hCAFE_BABE);
    expect_mf("op12_lo", c_MFLO, 32'hDEAD_BEEF);

    @(posedge clk);
    #1 md_valid = 1'b0;
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ex_md_unit.md
Name: ex_md_unit

Overview:
- Execute-stage multiply/divide unit of the 5-stage MIPS pipeline; sits directly downstream of the ID-stage bypass network.
- Consumes the forwarded rs/rt operands and owns the HI/LO registers.
- Produces EX_MD_data, which the ID bypass network forwards as the EX result for MFHI/MFLO.
- Raises md_stall while an iterative divide is in flight so the pipeline holds the divide in EX.

Parameters:
HILO_RESET  32'h0  reset value loaded into both HI and LO

Ports:
clk         input   1   pipeline clock; all state updates on rising edge
reset       input   1   synchronous, active-high reset
md_valid    input   1   a valid instruction is in EX with md_op meaningful
md_op       input   4   0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9-15 treated as none
md_cancel   input   1   EX flush (exception/eret); kills current op
rs_data     input   32  forwarded rs operand (dividend / multiplicand / MTxx source)
rt_data     input   32  forwarded rt operand (divisor / multiplier)
EX_MD_data  output  32  HI for MFHI, LO for MFLO, else 0
md_stall    output  1   hold IF/ID/EX; divide not yet complete
md_busy     output  1   state != IDLE

Behaviour:
- Reset: one clock and reset; reset is synchronous and active-high.
  - HI = LO = HILO_RESET; state = IDLE; counter = 0.
  - md_stall = 0; md_busy = 0; EX_MD_data = 0 (md_valid is 0 out of reset).
- EX_MD_data is combinational from the current registers: md_valid & op==MFHI -> HI; md_valid & op==MFLO -> LO; else 0.
  - No internal HI/LO forwarding is needed, because an op updates HI/LO at the end of the cycle it leaves EX.
- Issue condition: state == IDLE & md_valid & !md_cancel.
- MULT/MULTU, single cycle, no stall:
  - {HI,LO} <= 64-bit product at the end of the issue cycle.
  - MULT multiplies the operands as signed 32-bit values (sign-extended); MULTU treats them as unsigned (zero-extended).
- MTHI/MTLO: HI (resp. LO) <= rs_data at the end of the issue cycle.
- DIV/DIVU use a radix-2 restoring divider with states IDLE, RUN, DONE.
  - IDLE -> RUN on issue of DIV/DIVU.
    - Latch |rs| and |rt| (raw values for DIVU), the quotient sign (rs[31]^rt[31]), the remainder sign (rs[31]), and a divisor-zero flag.
    - counter <= 0.
  - RUN, each cycle: shift one dividend bit into the partial remainder; subtract the divisor when remainder >= divisor; set the quotient bit.
    - counter++; RUN -> DONE when counter == 31, i.e. 32 RUN cycles.
  - DONE -> IDLE unconditionally.
    - At the end of the DONE cycle: LO <= signed-corrected quotient; HI <= signed-corrected remainder.
    - The remainder takes the sign of the dividend.
  - Divisor zero (DIV and DIVU alike): LO <= 32'hFFFFFFFF, HI <= rs as latched (raw), no sign correction.
  - Signed overflow 0x80000000 / -1: LO = 0x80000000, HI = 0 (natural result of magnitude arithmetic).
- md_stall = (IDLE & md_valid & !md_cancel & op in {DIV, DIVU}) | (state == RUN).
  - md_stall is low in DONE, so the divide leaves EX at the end of DONE.
  - Issue cycle to release is 33 stalled cycles; the instruction following the divide sees the new HI/LO.
- In RUN and DONE, md_valid/md_op are ignored. The same divide is still presented and must not re-issue.
- md_cancel:
  - In the issue cycle: nothing starts and no HI/LO write occurs.
  - In RUN or DONE: state <= IDLE next edge; HI/LO unchanged; md_stall drops combinationally in RUN.
- reset mid-divide: takes priority over everything; back to IDLE, HI/LO = HILO_RESET.
- reset and md_cancel together: reset wins.

Test Plan:
1. MULT rs=0xFFFFFFFD (-3), rt=5 -> next cycle HI=0xFFFFFFFF, LO=0xFFFFFFF1; md_stall never 1. MULTU 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
2. DIV rs=0xFFFFFFF9 (-7), rt=2 held valid -> md_stall=1 for exactly 33 cycles, 0 in DONE. Then LO=0xFFFFFFFD, HI=0xFFFFFFFF; MFHI in the next cycle gives EX_MD_data=0xFFFFFFFF.
3. DIVU rs=0x12345678, rt=0 -> after 34 cycles LO=0xFFFFFFFF, HI=0x12345678. DIVU 100/7 -> LO=14, HI=2.
4. HI=LO=0x11111111 preset via MTHI/MTLO, start DIV 50/5, assert md_cancel at RUN cycle 10 -> md_stall drops that cycle; state IDLE next; HI=LO=0x11111111; a new DIV issues immediately.
5. reset asserted at RUN cycle 20 -> next edge HI=LO=0, md_busy=0, md_stall=0; DIV 9/3 then gives LO=3, HI=0.
6. MTHI 0xCAFEBABE, MTLO 0xDEADBEEF on back-to-back cycles -> MFHI/MFLO return those values. MFHI with md_valid=0 -> EX_MD_data=0. op=12 -> no state change.
